// File: rtl/regfile_multiport_clr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// regfile_multiport_clr : multi-port register file with post-reset clear sweep
// Revision: 1.0
// ============================================================================
module regfile_multiport_clr #(
  parameter int W_PORTS        = 2,
  parameter int R_PORTS        = 4,
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 8,
  parameter int ZERO_REG       = 1,
  parameter int RDW_MODE       = 0,
  parameter int WPRIO          = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [W_PORTS-1:0] i_w_e,
  input  logic [AW-1:0]      i_w_addr [W_PORTS],
  input  logic [WIDTH-1:0]   i_w_data [W_PORTS],
  input  logic [R_PORTS-1:0] i_r_e,
  input  logic [AW-1:0]      i_r_addr [R_PORTS],
  output logic [WIDTH-1:0]   o_r_data [R_PORTS],
  output logic               o_ready,
  output logic [W_PORTS-1:0] o_w_drop
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [AW-1:0]      r_clr_cnt;
  logic [AW-1:0]      w_clr_cnt_nxt;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_active;
  logic [W_PORTS-1:0] w_blocked;
  logic [W_PORTS-1:0] w_zero;
  logic [W_PORTS-1:0] w_eff;
  logic [W_PORTS-1:0] w_drop;
  logic [WIDTH-1:0]   w_rd [R_PORTS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    if (r_state == ST_CLEAR) begin
      w_clr_cnt_nxt = r_clr_cnt + AW'(1);
      if (r_clr_cnt == AW'(DEPTH - 1)) begin
        w_state_nxt = ST_READY;
      end
    end
  end

  assign w_active = (r_state == ST_READY) && !i_rst;
  assign o_ready  = i_rst ? (CLEAR_ON_RESET == 0) : (r_state == ST_READY);

  // Any enabled port of higher priority on the same address blocks this one.
  always_comb begin
    w_blocked = '0;
    w_zero    = '0;
    w_eff     = '0;
    w_drop    = '0;
    for (int p = 0; p < W_PORTS; p++) begin
      for (int q = 0; q < W_PORTS; q++) begin
        if (q != p && i_w_e[q] && i_w_addr[q] == i_w_addr[p]) begin
          if ((WPRIO == 0 && q < p) || (WPRIO != 0 && q > p)) begin
            w_blocked[p] = 1'b1;
          end
        end
      end
      w_zero[p] = (ZERO_REG != 0) && (i_w_addr[p] == '0);
      w_eff[p]  = w_active && i_w_e[p] && !w_zero[p] && !w_blocked[p];
      w_drop[p] = w_active && i_w_e[p] && !w_eff[p];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_cnt] <= '0;
      end else begin
        for (int p = 0; p < W_PORTS; p++) begin
          if (w_eff[p]) begin
            r_mem[i_w_addr[p]] <= i_w_data[p];
          end
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < R_PORTS; r++) begin
      w_rd[r] = r_mem[i_r_addr[r]];
      if (RDW_MODE != 0) begin
        for (int p = 0; p < W_PORTS; p++) begin
          if (w_eff[p] && i_w_addr[p] == i_r_addr[r]) begin
            w_rd[r] = i_w_data[p];
          end
        end
      end
      if ((ZERO_REG != 0) && (i_r_addr[r] == '0)) begin
        w_rd[r] = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_w_drop <= '0;
      for (int r = 0; r < R_PORTS; r++) begin
        o_r_data[r] <= '0;
      end
    end else begin
      o_w_drop <= w_drop;
      for (int r = 0; r < R_PORTS; r++) begin
        if (w_active && i_r_e[r]) begin
          o_r_data[r] <= w_rd[r];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport_clr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_regfile_multiport_clr : vector-table bench, two DUTs (WPRIO/RDW 0 and 1)
// Revision: 1.0
// ============================================================================
module tb_regfile_multiport_clr;
  localparam int WP = 2;
  localparam int RP = 4;
  localparam int WD = 32;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [WP-1:0] w_e;
  logic [AW-1:0] w_addr [WP];
  logic [WD-1:0] w_data [WP];
  logic [RP-1:0] r_e;
  logic [AW-1:0] r_addr [RP];
  logic [WD-1:0] rd_a [RP];
  logic [WD-1:0] rd_b [RP];
  logic          rdy_a, rdy_b;
  logic [WP-1:0] drop_a, drop_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_multiport_clr #(
    .W_PORTS(WP), .R_PORTS(RP), .WIDTH(WD), .DEPTH(DP),
    .ZERO_REG(1), .RDW_MODE(0), .WPRIO(0), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_w_e(w_e), .i_w_addr(w_addr), .i_w_data(w_data),
    .i_r_e(r_e), .i_r_addr(r_addr), .o_r_data(rd_a), .o_ready(rdy_a), .o_w_drop(drop_a)
  );

  regfile_multiport_clr #(
    .W_PORTS(WP), .R_PORTS(RP), .WIDTH(WD), .DEPTH(DP),
    .ZERO_REG(1), .RDW_MODE(1), .WPRIO(1), .CLEAR_ON_RESET(1)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_w_e(w_e), .i_w_addr(w_addr), .i_w_data(w_data),
    .i_r_e(r_e), .i_r_addr(r_addr), .o_r_data(rd_b), .o_ready(rdy_b), .o_w_drop(drop_b)
  );

  typedef struct {
    string       name;
    logic [1:0]  we;
    logic [2:0]  wa0;
    logic [31:0] wd0;
    logic [2:0]  wa1;
    logic [31:0] wd1;
    logic [3:0]  re;
    logic [2:0]  lo;
    logic [2:0]  hi;
    logic [31:0] lo_a, hi_a, lo_b, hi_b;
    logic [1:0]  dr_a, dr_b;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] lo_a, hi_a, lo_b, hi_b;
    logic [1:0]  dr_a, dr_b;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    w_e = '0;
    r_e = '0;
    for (int p = 0; p < WP; p++) begin
      w_addr[p] = '0;
      w_data[p] = '0;
    end
    for (int r = 0; r < RP; r++) r_addr[r] = '0;
  endtask

  task automatic drive(input vec_t v);
    w_e       = v.we;
    w_addr[0] = v.wa0;
    w_data[0] = v.wd0;
    w_addr[1] = v.wa1;
    w_data[1] = v.wd1;
    r_e       = v.re;
    r_addr[0] = v.lo;
    r_addr[1] = v.lo;
    r_addr[2] = v.hi;
    r_addr[3] = v.hi;
  endtask

  task automatic compare_pending();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, ".a0"}, rd_a[0], e.lo_a);
      chk({e.name, ".a1"}, rd_a[1], e.lo_a);
      chk({e.name, ".a2"}, rd_a[2], e.hi_a);
      chk({e.name, ".a3"}, rd_a[3], e.hi_a);
      chk({e.name, ".b0"}, rd_b[0], e.lo_b);
      chk({e.name, ".b1"}, rd_b[1], e.lo_b);
      chk({e.name, ".b2"}, rd_b[2], e.hi_b);
      chk({e.name, ".b3"}, rd_b[3], e.hi_b);
      chk({e.name, ".drop_a"}, 32'(drop_a), 32'(e.dr_a));
      chk({e.name, ".drop_b"}, 32'(drop_b), 32'(e.dr_b));
    end
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      compare_pending();
      drive(vt[i]);
      sb.push_back(exp_t'{vt[i].name, vt[i].lo_a, vt[i].hi_a, vt[i].lo_b, vt[i].hi_b,
                          vt[i].dr_a, vt[i].dr_b});
    end
    @(negedge clk);
    compare_pending();
    idle();
  endtask

  // Counts clock cycles from reset release until o_ready is seen high.
  task automatic wait_ready(input string name);
    int n  = 0;
    int na = 0;
    int nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      chk({name, ".clr_drop_a"}, 32'(drop_a), 32'h0);
      chk({name, ".clr_drop_b"}, 32'(drop_b), 32'h0);
      if (rdy_a && na == 0) na = n;
      if (rdy_b && nb == 0) nb = n;
      if (na != 0 && nb != 0) break;
    end
    chk({name, ".ready_lat_a"}, 32'(na), 32'd8);
    chk({name, ".ready_lat_b"}, 32'(nb), 32'd8);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // name, we, wa0, wd0, wa1, wd1, re, lo, hi, lo_a, hi_a, lo_b, hi_b, dr_a, dr_b
    vt.push_back(vec_t'{"rd01", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'hF, 3'd0, 3'd1, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00});
    vt.push_back(vec_t'{"rd23", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'hF, 3'd2, 3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00});
    vt.push_back(vec_t'{"rd45", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'hF, 3'd4, 3'd5, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00});
    vt.push_back(vec_t'{"rd67", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'hF, 3'd6, 3'd7, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00});
    vt.push_back(vec_t'{"coll3", 2'b11, 3'd3, 32'hAAAA, 3'd3, 32'h5555, 4'hF, 3'd3, 3'd6, 32'h0, 32'h0, 32'h5555, 32'h0, 2'b10, 2'b01});
    vt.push_back(vec_t'{"wr5", 2'b01, 3'd5, 32'h11, 3'd0, 32'h0, 4'hF, 3'd3, 3'd7, 32'hAAAA, 32'h0, 32'h5555, 32'h0, 2'b00, 2'b00});
    vt.push_back(vec_t'{"rdw5", 2'b01, 3'd5, 32'h22, 3'd0, 32'h0, 4'hF, 3'd5, 3'd3, 32'h11, 32'hAAAA, 32'h22, 32'h5555, 2'b00, 2'b00});
    vt.push_back(vec_t'{"zero0", 2'b11, 3'd0, 32'hFFFF, 3'd6, 32'h66, 4'hF, 3'd0, 3'd5, 32'h0, 32'h22, 32'h0, 32'h22, 2'b01, 2'b01});
    vt.push_back(vec_t'{"hold", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'h0, 3'd6, 3'd6, 32'h0, 32'h22, 32'h0, 32'h22, 2'b00, 2'b00});
    vt.push_back(vec_t'{"rd60", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'hF, 3'd6, 3'd0, 32'h66, 32'h0, 32'h66, 32'h0, 2'b00, 2'b00});
    vt.push_back(vec_t'{"zero_both", 2'b11, 3'd0, 32'hFFFF, 3'd0, 32'hFFFF, 4'hF, 3'd0, 3'd6, 32'h0, 32'h66, 32'h0, 32'h66, 2'b11, 2'b11});
    vt.push_back(vec_t'{"dual_wr", 2'b11, 3'd2, 32'h1234, 3'd7, 32'h7777, 4'hF, 3'd2, 3'd7, 32'h0, 32'h0, 32'h1234, 32'h7777, 2'b00, 2'b00});
    vt.push_back(vec_t'{"rd27", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'hF, 3'd2, 3'd7, 32'h1234, 32'h7777, 32'h1234, 32'h7777, 2'b00, 2'b00});
    vt.push_back(vec_t'{"coll4_rdw", 2'b11, 3'd4, 32'h4040, 3'd4, 32'h0404, 4'hF, 3'd4, 3'd4, 32'h0, 32'h0, 32'h0404, 32'h0404, 2'b10, 2'b01});
    vt.push_back(vec_t'{"rd45b", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'hF, 3'd4, 3'd5, 32'h4040, 32'h22, 32'h0404, 32'h22, 2'b00, 2'b00});
    vt.push_back(vec_t'{"post_rst45", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'hF, 3'd4, 3'd5, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00});
    vt.push_back(vec_t'{"post_rst67", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'hF, 3'd6, 3'd7, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00});
    vt.push_back(vec_t'{"post_rst23", 2'b00, 3'd0, 32'h0, 3'd0, 32'h0, 4'hF, 3'd2, 3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00});

    // Reset for two cycles.
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("rst.ready_a", 32'(rdy_a), 32'h0);
    chk("rst.ready_b", 32'(rdy_b), 32'h0);
    chk("rst.rdata_a", rd_a[0], 32'h0);
    chk("rst.drop_a", 32'(drop_a), 32'h0);

    // Release; writes and reads presented during the sweep must be ignored.
    rst       = 1'b0;
    w_e       = 2'b11;
    w_addr[0] = 3'd1;
    w_data[0] = 32'hDEAD;
    w_addr[1] = 3'd2;
    w_data[1] = 32'hBEEF;
    r_e       = 4'hF;
    for (int r = 0; r < RP; r++) r_addr[r] = 3'd5;
    wait_ready("clr1");
    chk("clr1.rdata_hold", rd_a[0], 32'h0);

    run_vecs(0, 14);

    // Reset mid-READY zeroes read data, then reset again at clr_cnt==4.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2.rdata_a", rd_a[0], 32'h0);
    chk("rst2.rdata_b", rd_b[0], 32'h0);
    chk("rst2.ready_a", 32'(rdy_a), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midclr.ready_a", 32'(rdy_a), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready("clr2");

    run_vecs(15, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_multiport_clr.md
REGFILE_MULTIPORT_CLR -- requirements
Module: regfile_multiport_clr

Interface
REQ-001 SHALL have parameter W_PORTS, default 2, number of write ports.
REQ-002 SHALL have parameter R_PORTS, default 4, number of read ports.
REQ-003 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-004 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2); AW = $clog2(DEPTH).
REQ-005 SHALL have parameter ZERO_REG, default 1; 1 = entry 0 reads as zero and ignores writes.
REQ-006 SHALL have parameter RDW_MODE, default 0; 0 = read-during-write returns old value, 1 = returns newly written value (bypass).
REQ-007 SHALL have parameter WPRIO, default 0; 0 = lowest-index write port wins a same-address collision, 1 = highest index wins.
REQ-008 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = all entries zeroed by a post-reset clear sweep.
REQ-009 SHALL have port i_clk, input, 1, single clock; all logic on its rising edge.
REQ-010 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-011 SHALL have port i_w_e, input, [W_PORTS-1:0], per-port write enable.
REQ-012 SHALL have port i_w_addr, input, [AW-1:0] x W_PORTS unpacked, write addresses.
REQ-013 SHALL have port i_w_data, input, [WIDTH-1:0] x W_PORTS unpacked, write data.
REQ-014 SHALL have port i_r_e, input, [R_PORTS-1:0], per-port read enable.
REQ-015 SHALL have port i_r_addr, input, [AW-1:0] x R_PORTS unpacked, read addresses.
REQ-016 SHALL have port o_r_data, output, [WIDTH-1:0] x R_PORTS unpacked, registered read data.
REQ-017 SHALL have port o_ready, output, 1, high when array accepts reads/writes (state READY).
REQ-018 SHALL have port o_w_drop, output, [W_PORTS-1:0], registered per-port flag: that port's write in the previous cycle was discarded.

Function
REQ-019 SHALL implement a two-state FSM: CLEAR, READY; reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-020 SHALL, in CLEAR, write zero to entry clr_cnt each cycle, clr_cnt starting at 0 and incrementing by 1.
REQ-021 SHALL transition CLEAR->READY on the cycle clr_cnt==DEPTH-1 is written; o_ready rises exactly DEPTH cycles after i_rst deasserts.
REQ-022 SHALL, in CLEAR, ignore all i_w_e and i_r_e; o_r_data holds, o_w_drop stays 0.
REQ-023 SHALL, in READY, qualify port p's write as effective when i_w_e[p]=1, not (ZERO_REG=1 and addr==0), and no higher-priority enabled port (per WPRIO) targets the same address.
REQ-024 SHALL commit every effective write at the clock edge; at most one write per address per cycle.
REQ-025 SHALL set o_w_drop[p]=1 next cycle iff i_w_e[p]=1 and the write was non-effective due to collision or the zero register; otherwise 0.
REQ-026 SHALL, in READY, update o_r_data[r] one cycle after i_r_e[r]=1 with entry i_r_addr[r]; hold when i_r_e[r]=0.
REQ-027 SHALL return zero for reads of address 0 when ZERO_REG=1, regardless of stored contents.
REQ-028 SHALL, for a read and effective write to the same address in one cycle, return the pre-write value if RDW_MODE=0 and the winning port's write data if RDW_MODE=1.
REQ-029 SHALL keep ineffective writes (dropped, zero reg, CLEAR) from ever altering array contents or bypass data.
REQ-030 SHALL, with CLEAR_ON_RESET=0, leave array contents undefined after reset; only outputs are reset.

Reset
REQ-031 SHALL, while i_rst=1, drive o_r_data all zero, o_w_drop zero, o_ready 0 (CLEAR_ON_RESET=1) or 1 (CLEAR_ON_RESET=0), clr_cnt 0.
REQ-032 SHALL, on i_rst asserted mid-CLEAR or mid-READY, abandon the current state and restart the sweep from entry 0 on deassert.
REQ-033 SHALL ignore writes and reads presented in any cycle where i_rst=1.

Verification
REQ-034 SHALL verify clear: DEPTH=8, reset 2 cycles then release -> o_ready low 8 cycles, high on 9th; reads of all 8 entries return 0.
REQ-035 SHALL verify collision: W_PORTS=2, both ports write addr 3 (0xAAAA port0, 0x5555 port1) -> WPRIO=0: entry 3=0xAAAA, o_w_drop=2'b10; WPRIO=1: 0x5555, 2'b01.
REQ-036 SHALL verify RDW: entry 5=0x11, same cycle write 0x22 and read addr 5 -> RDW_MODE=0 returns 0x11, RDW_MODE=1 returns 0x22; next read returns 0x22.
REQ-037 SHALL verify zero register: write 0xFFFF to addr 0 with ZERO_REG=1 -> o_w_drop[p]=1, read addr 0 returns 0.
REQ-038 SHALL verify reset mid-clear: assert i_rst at clr_cnt=4, release -> o_ready low a full 8 cycles again; entries written before reset read 0.
